// File: rtl/pocket_video_out.sv
// Converts raw core video (syncs, blanks, CE, N-bit colour) into a two-stage registered
// stream of single-cycle syncs, de/skip and 24-bit rgb, plus line/frame measurement.
module pocket_video_out #(
  parameter int COLOR_BITS  = 4,
  parameter int EXPAND_MODE = 1,
  parameter int CE_STRETCH  = 2,
  parameter int HS_POSITIVE = 1,
  parameter int VS_POSITIVE = 1,
  parameter int CNT_W       = 12
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  ce_in,
  input  logic                  hsync_in,
  input  logic                  vsync_in,
  input  logic                  hblank_in,
  input  logic                  vblank_in,
  input  logic [COLOR_BITS-1:0] r_in,
  input  logic [COLOR_BITS-1:0] g_in,
  input  logic [COLOR_BITS-1:0] b_in,
  input  logic                  clear_err,
  output logic                  hs,
  output logic                  vs,
  output logic                  de,
  output logic                  skip,
  output logic [23:0]           rgb,
  output logic [CNT_W-1:0]      line_pixels,
  output logic [CNT_W-1:0]      frame_lines,
  output logic                  err_hs_in_de
);

  localparam logic [3:0] STRETCH_LOAD = 4'(CE_STRETCH - 1);

  logic                  ce_s1, hs_s1, vs_s1, hblank_s1, vblank_s1, clear_s1;
  logic [COLOR_BITS-1:0] r_s1, g_s1, b_s1;
  logic                  hs_prev, vs_prev, de_prev;
  logic [3:0]            stretch_cnt;
  logic [CNT_W-1:0]      pix_cnt, line_cnt, line_next;
  logic                  hs_act, vs_act, de_s1, hs_pulse, vs_pulse, held, pixel, de_fall;

  function automatic logic [7:0] expand(input logic [COLOR_BITS-1:0] c);
    logic [7:0] e;
    e = '0;
    for (int i = 0; i < 8; i++) begin
      if (EXPAND_MODE != 0 || i < COLOR_BITS)
        e[7-i] = c[COLOR_BITS-1-(i % COLOR_BITS)];
    end
    return e;
  endfunction

  assign hs_act    = (HS_POSITIVE != 0) ? hsync_in : ~hsync_in;
  assign vs_act    = (VS_POSITIVE != 0) ? vsync_in : ~vsync_in;
  assign de_s1     = ~(hblank_s1 | vblank_s1);
  assign hs_pulse  = hs_s1 & ~hs_prev;
  assign vs_pulse  = vs_s1 & ~vs_prev;
  assign held      = ce_s1 | (stretch_cnt != 4'd0);
  assign pixel     = ce_s1 & de_s1;
  assign de_fall   = de_prev & ~de_s1;
  assign line_next = (de_fall && line_cnt != '1) ? line_cnt + 1'b1 : line_cnt;

  // Syncs reset to the active level so a sync already held at reset needs a fresh edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ce_s1     <= 1'b0;
      hs_s1     <= 1'b1;
      vs_s1     <= 1'b1;
      hblank_s1 <= 1'b1;
      vblank_s1 <= 1'b1;
      clear_s1  <= 1'b0;
      r_s1      <= '0;
      g_s1      <= '0;
      b_s1      <= '0;
    end else begin
      ce_s1     <= ce_in;
      hs_s1     <= hs_act;
      vs_s1     <= vs_act;
      hblank_s1 <= hblank_in;
      vblank_s1 <= vblank_in;
      clear_s1  <= clear_err;
      r_s1      <= r_in;
      g_s1      <= g_in;
      b_s1      <= b_in;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hs          <= 1'b0;
      vs          <= 1'b0;
      de          <= 1'b0;
      skip        <= 1'b0;
      rgb         <= '0;
      hs_prev     <= 1'b1;
      vs_prev     <= 1'b1;
      de_prev     <= 1'b0;
      stretch_cnt <= 4'd0;
    end else begin
      hs      <= hs_pulse;
      vs      <= vs_pulse;
      de      <= de_s1;
      skip    <= de_s1 & ~held;
      rgb     <= de_s1 ? {expand(r_s1), expand(g_s1), expand(b_s1)} : 24'd0;
      hs_prev <= hs_s1;
      vs_prev <= vs_s1;
      de_prev <= de_s1;
      if (ce_s1)
        stretch_cnt <= STRETCH_LOAD;
      else if (stretch_cnt != 4'd0)
        stretch_cnt <= stretch_cnt - 1'b1;
    end
  end

  // A pixel coinciding with the hs pulse belongs to the new line; a de fall
  // coinciding with vs belongs to the frame just ending.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pix_cnt      <= '0;
      line_pixels  <= '0;
      line_cnt     <= '0;
      frame_lines  <= '0;
      err_hs_in_de <= 1'b0;
    end else begin
      if (hs_pulse) begin
        line_pixels <= pix_cnt;
        pix_cnt     <= CNT_W'(pixel);
      end else if (pixel && pix_cnt != '1) begin
        pix_cnt <= pix_cnt + 1'b1;
      end
      if (vs_pulse) begin
        frame_lines <= line_next;
        line_cnt    <= '0;
      end else begin
        line_cnt <= line_next;
      end
      if (hs_pulse && de_s1)
        err_hs_in_de <= 1'b1;
      else if (clear_s1)
        err_hs_in_de <= 1'b0;
    end
  end

endmodule
